// File: rtl/riscv_csrbus_pkg.sv
// rtl/riscv_csrbus_pkg.sv - shared CSR bus encodings
package riscv_csrbus_pkg;

    typedef enum logic [2:0] {
        CSRRW  = 3'b001,
        CSRRS  = 3'b010,
        CSRRC  = 3'b011,
        CSRRWI = 3'b101,
        CSRRSI = 3'b110,
        CSRRCI = 3'b111
    } csr_funct3_e;

    // csr[11:10] value that marks a CSR as read-only
    localparam logic [1:0] CSR_RO_FIELD = 2'b11;

endpackage

// File: rtl/riscv_csrbus_if.sv
// rtl/riscv_csrbus_if.sv - core-to-bridge CSR instruction bus
interface riscv_csrbus_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic [2:0]      funct3;
    logic [11:0]     csr;
    logic [4:0]      rs1;
    logic [XLEN-1:0] rs1_value;
    logic            ready;
    logic [XLEN-1:0] rd_value;
    logic            error;

    modport master (
        output valid, funct3, csr, rs1, rs1_value,
        input  ready, rd_value, error
    );

    modport slave (
        input  valid, funct3, csr, rs1, rs1_value,
        output ready, rd_value, error
    );
endinterface

// File: rtl/riscv_csr_alu.sv
// rtl/riscv_csr_alu.sv - CSR read-modify-write value and write-enable decode
module riscv_csr_alu
    import riscv_csrbus_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      rs1_i,
    input  logic [XLEN-1:0] rs1_value_i,
    input  logic [XLEN-1:0] old_value_i,
    output logic [XLEN-1:0] new_value_o,
    output logic            write_needed_o,
    output logic            illegal_op_o
);

    logic [XLEN-1:0] operand;

    assign operand = funct3_i[2] ? {{(XLEN-5){1'b0}}, rs1_i} : rs1_value_i;

    // Set/clear forms skip the write when the rs1 index (not its value) is x0
    always_comb begin
        new_value_o    = '0;
        write_needed_o = 1'b0;
        illegal_op_o   = 1'b0;
        case (csr_funct3_e'(funct3_i))
            CSRRW, CSRRWI: begin
                new_value_o    = operand;
                write_needed_o = 1'b1;
            end
            CSRRS, CSRRSI: begin
                new_value_o    = old_value_i | operand;
                write_needed_o = (rs1_i != 5'd0);
            end
            CSRRC, CSRRCI: begin
                new_value_o    = old_value_i & ~operand;
                write_needed_o = (rs1_i != 5'd0);
            end
            default: illegal_op_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/riscv_csrbus_bridge.sv
// rtl/riscv_csrbus_bridge.sv - CSR bus slave issuing read and optional write on the register bus
module riscv_csrbus_bridge
    import riscv_csrbus_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    riscv_csrbus_if.slave   csrbus,
    output logic            o_reg_valid,
    output logic            o_reg_write,
    output logic [11:0]     o_reg_address,
    output logic [XLEN-1:0] o_reg_write_data,
    input  logic            i_reg_ready,
    input  logic [XLEN-1:0] i_reg_read_data,
    input  logic            i_reg_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESPOND
    } state_e;

    state_e          state_q;
    logic            reg_valid_q;
    logic            reg_write_q;
    logic [11:0]     reg_addr_q;
    logic [XLEN-1:0] reg_wdata_q;
    logic            ready_q;
    logic [XLEN-1:0] rd_value_q;
    logic            error_q;
    logic [XLEN-1:0] old_value_q;

    logic [XLEN-1:0] alu_new_value;
    logic            alu_write_needed;
    logic            alu_illegal_op;

    // The ALU only matters for new_value in READ, where the read data is live
    riscv_csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3_i       (csrbus.funct3),
        .rs1_i          (csrbus.rs1),
        .rs1_value_i    (csrbus.rs1_value),
        .old_value_i    (i_reg_read_data),
        .new_value_o    (alu_new_value),
        .write_needed_o (alu_write_needed),
        .illegal_op_o   (alu_illegal_op)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            reg_valid_q <= 1'b0;
            reg_write_q <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            ready_q     <= 1'b0;
            rd_value_q  <= '0;
            error_q     <= 1'b0;
            old_value_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (csrbus.valid) begin
                        reg_addr_q <= csrbus.csr;
                        if (alu_illegal_op) begin
                            state_q    <= S_RESPOND;
                            ready_q    <= 1'b1;
                            error_q    <= 1'b1;
                            rd_value_q <= '0;
                        end else begin
                            state_q     <= S_READ;
                            reg_valid_q <= 1'b1;
                            reg_write_q <= 1'b0;
                        end
                    end
                end
                S_READ: begin
                    if (i_reg_ready) begin
                        old_value_q <= i_reg_read_data;
                        if (i_reg_error ||
                            (alu_write_needed && reg_addr_q[11:10] == CSR_RO_FIELD)) begin
                            state_q     <= S_RESPOND;
                            reg_valid_q <= 1'b0;
                            ready_q     <= 1'b1;
                            error_q     <= 1'b1;
                            rd_value_q  <= '0;
                        end else if (alu_write_needed) begin
                            state_q     <= S_WRITE;
                            reg_write_q <= 1'b1;
                            reg_wdata_q <= alu_new_value;
                        end else begin
                            state_q     <= S_RESPOND;
                            reg_valid_q <= 1'b0;
                            ready_q     <= 1'b1;
                            error_q     <= 1'b0;
                            rd_value_q  <= i_reg_read_data;
                        end
                    end
                end
                S_WRITE: begin
                    if (i_reg_ready) begin
                        state_q     <= S_RESPOND;
                        reg_valid_q <= 1'b0;
                        reg_write_q <= 1'b0;
                        ready_q     <= 1'b1;
                        error_q     <= i_reg_error;
                        rd_value_q  <= i_reg_error ? '0 : old_value_q;
                    end
                end
                S_RESPOND: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_reg_valid      = reg_valid_q;
    assign o_reg_write      = reg_write_q;
    assign o_reg_address    = reg_addr_q;
    assign o_reg_write_data = reg_wdata_q;

    assign csrbus.ready    = ready_q;
    assign csrbus.rd_value = rd_value_q;
    assign csrbus.error    = error_q;

endmodule
